// File: rtl/mtr_duty_ctrl.sv
// Speed command to PWM duty word: clamp, per-period slew limit, and an
// over-current leaky bucket that latches a zero-torque fault.
module mtr_duty_ctrl #(
  parameter logic [10:0] SLEW_STEP = 11'd16,
  parameter logic [10:0] DUTY_MIN  = 11'h080,
  parameter logic [10:0] DUTY_MAX  = 11'h780,
  parameter logic [7:0]  OVR_LIMIT = 8'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] spd,
  input  logic        en,
  input  logic        PWM_synch,
  input  logic        ovr_I_blank,
  input  logic        OVR_I,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        fault,
  output logic [7:0]  ovr_cnt
);

  localparam logic [10:0] DUTY_ZERO = 11'h400;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic        period_ovr;
  logic [10:0] raw, tgt, duty_slew;
  logic [11:0] d12, t12, s12;
  logic [7:0]  cnt_upd;
  logic        ovr_q, trip, clr_now;

  // Offset-binary conversion: 0x400 + spd>>>1 is just the MSB flipped.
  assign raw   = en ? {~spd[11], spd[10:1]} : DUTY_ZERO;
  assign ovr_q = OVR_I & ~ovr_I_blank;

  always_comb begin
    tgt = raw;
    if (raw < DUTY_MIN) tgt = DUTY_MIN;
    else if (raw > DUTY_MAX) tgt = DUTY_MAX;
    if (state == FAULT) tgt = DUTY_ZERO;
  end

  // 12-bit compare so duty+step / tgt+step never wrap.
  assign d12 = {1'b0, duty};
  assign t12 = {1'b0, tgt};
  assign s12 = {1'b0, SLEW_STEP};

  always_comb begin
    duty_slew = tgt;
    if (t12 > d12 + s12)      duty_slew = duty + SLEW_STEP;
    else if (t12 + s12 < d12) duty_slew = duty - SLEW_STEP;
  end

  always_comb begin
    cnt_upd = ovr_cnt;
    if (period_ovr) cnt_upd = (ovr_cnt >= 8'hFE) ? 8'hFF : ovr_cnt + 8'd2;
    else if (ovr_cnt != 8'd0) cnt_upd = ovr_cnt - 8'd1;
  end

  assign trip    = (state == RUN) && PWM_synch && (cnt_upd >= OVR_LIMIT);
  assign clr_now = (state == FAULT) && clr_fault;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (trip) state_nxt = FAULT;
      FAULT:   if (clr_fault) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      duty       <= DUTY_ZERO;
      fault      <= 1'b0;
      ovr_cnt    <= 8'd0;
      period_ovr <= 1'b0;
    end else begin
      state <= state_nxt;
      // A synch consumes the period flag; a qualifying sample on it starts the next period.
      if (PWM_synch)  period_ovr <= ovr_q;
      else if (ovr_q) period_ovr <= 1'b1;
      if (clr_now) begin
        ovr_cnt    <= 8'd0;
        period_ovr <= 1'b0;
        fault      <= 1'b0;
      end else if (state == RUN && PWM_synch) begin
        ovr_cnt <= cnt_upd;
        if (trip) begin
          fault <= 1'b1;
          duty  <= DUTY_ZERO;
        end else begin
          duty  <= duty_slew;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Directed bench for mtr_duty_ctrl: vector table for the basic slew, then
// hand sequences for clamping, over-current, fault clear and reset.
module tb_mtr_duty_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, PWM_synch, ovr_I_blank, OVR_I, clr_fault;
  logic [11:0] spd;
  logic [10:0] duty;
  logic        fault;
  logic [7:0]  ovr_cnt;

  int checks = 0;
  int passed = 0;

  mtr_duty_ctrl dut (
    .clk(clk), .rst(rst), .spd(spd), .en(en), .PWM_synch(PWM_synch),
    .ovr_I_blank(ovr_I_blank), .OVR_I(OVR_I), .clr_fault(clr_fault),
    .duty(duty), .fault(fault), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en;
    logic [11:0] spd;
    logic        syn, blk, ovr, clr;
    logic [10:0] e_duty;
    logic        e_fault;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [11:0] s, logic sy, logic b, logic o,
                              logic c, logic [10:0] ed, logic ef, logic [7:0] ec);
    vec_t v;
    v.rst = r; v.en = e; v.spd = s; v.syn = sy; v.blk = b; v.ovr = o; v.clr = c;
    v.e_duty = ed; v.e_fault = ef; v.e_cnt = ec;
    return v;
  endfunction

  // One clock: drive, take the edge, settle 1 time unit past it.
  task automatic cyc(input logic r, input logic s, input logic b, input logic o, input logic c);
    rst = r; PWM_synch = s; ovr_I_blank = b; OVR_I = o; clr_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [10:0] ed, input logic ef, input logic [7:0] ec);
    checks++;
    if (duty === ed && fault === ef && ovr_cnt === ec) passed++;
    else $display("FAIL %s: got duty=%h fault=%b cnt=%0d, want duty=%h fault=%b cnt=%0d",
                  nm, duty, fault, ovr_cnt, ed, ef, ec);
  endtask

  // Slew to target one synch per period; counts synchs and checks every step is exactly 16.
  task automatic slew_to(input logic [10:0] tg, input int exp_n, input string nm);
    int n = 0;
    int bad = 0;
    logic [10:0] prev;
    while (duty !== tg && n < 300) begin
      prev = duty;
      cyc(0, 0, 0, 0, 0);
      if (duty !== prev) bad++;
      cyc(0, 1, 0, 0, 0);
      n++;
      if (duty !== tg && duty !== prev + 11'd16 && duty !== prev - 11'd16) bad++;
    end
    checks++;
    if (duty === tg && n == exp_n && bad == 0) passed++;
    else $display("FAIL %s: got duty=%h after %0d synchs (%0d bad steps), want duty=%h after %0d",
                  nm, duty, n, bad, tg, exp_n);
  endtask

  initial begin
    logic [10:0] d;
    en = 1'b1; spd = 12'd400;
    cyc(1, 0, 0, 0, 0);

    // Test 1 table: spd=400 -> tgt 0x4C8; spd wiggles between synchs must not move duty
    tbl.push_back(mk(1, 1, 12'd400, 1, 0, 0, 0, 11'h400, 0, 0));
    d = 11'h400;
    for (int k = 1; k <= 13; k++) begin
      tbl.push_back(mk(0, k % 3 != 0, (k % 2) ? 12'h800 : 12'h7FF, 0, 0, 0, 0, d, 0, 0));
      d = (k == 13) ? 11'h4C8 : 11'h400 + 11'(16 * k);
      tbl.push_back(mk(0, 1, 12'd400, 1, 0, 0, 0, d, 0, 0));
    end
    tbl.push_back(mk(0, 1, 12'd400, 1, 0, 0, 0, 11'h4C8, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; spd = tbl[i].spd;
      cyc(tbl[i].rst, tbl[i].syn, tbl[i].blk, tbl[i].ovr, tbl[i].clr);
      chk($sformatf("vec%0d", i), tbl[i].e_duty, tbl[i].e_fault, tbl[i].e_cnt);
    end

    // Test 2: clamp high, clamp low, disable back to zero torque
    spd = 12'h7FF; slew_to(11'h780, 44, "clamp_hi");
    spd = 12'h800; slew_to(11'h080, 112, "clamp_lo");
    en = 1'b0;     slew_to(11'h400, 56, "en_off");

    // Test 3: persistent over-current from full duty trips on the 16th synch
    en = 1'b1; spd = 12'h7FF; slew_to(11'h780, 56, "to_max");
    for (int k = 1; k <= 15; k++) begin
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
    end
    chk("ovr_15", 11'h780, 0, 8'd30);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    chk("ovr_trip", 11'h400, 1, 8'd32);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    chk("fault_frozen", 11'h400, 1, 8'd32);
    cyc(0, 1, 0, 0, 0);
    chk("fault_latched", 11'h400, 1, 8'd32);

    // Test 5: clear coincident with synch wins; next synch slews +16
    cyc(0, 1, 0, 1, 1);
    chk("clr_synch", 11'h400, 0, 8'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("after_clr", 11'h410, 0, 8'd0);
    cyc(0, 0, 0, 0, 1);
    chk("clr_in_run", 11'h410, 0, 8'd0);

    // Test 4: blanked over-current ignored; sample on a synch counts next period
    spd = 12'd0;
    cyc(1, 0, 0, 0, 0);
    chk("reset2", 11'h400, 0, 8'd0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    chk("blanked", 11'h400, 0, 8'd0);
    cyc(0, 1, 0, 1, 0);
    chk("ovr_on_synch", 11'h400, 0, 8'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("counted_next", 11'h400, 0, 8'd2);
    cyc(0, 1, 0, 0, 0);
    chk("leak", 11'h400, 0, 8'd1);

    // Test 6: reset mid-slew with pending over-current
    cyc(1, 0, 0, 0, 0);
    spd = 12'd400;
    for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0);
    chk("pre_rst", 11'h460, 0, 8'd0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    chk("pre_rst_cnt", 11'h470, 0, 8'd2);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    chk("mid_rst", 11'h400, 0, 8'd0);
    cyc(0, 1, 0, 0, 0);
    chk("post_rst", 11'h410, 0, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
